// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cond_pkg
// Purpose : Shared constants for the condition/flag logic. Holds the bit
//           positions of the {N,Z,C,V} flag vector and the 4-bit branch /
//           predication condition-code encodings.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package cond_pkg;

  // Bit positions inside the 4-bit flag vector {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;  // C=1 means borrow (unsigned in1 < in2)
  localparam int FLAG_V = 0;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_LO = 4'd2;
  localparam logic [3:0] COND_HS = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module  : cond_eval
// Purpose : Purely combinational evaluation of a 4-bit condition code
//           against a {N,Z,C,V} flag vector.
// Ports   : i_flags [3:0] flag vector {N,Z,C,V}
//           i_cond  [3:0] condition code
//           o_taken       1 when the condition holds
// Rev     : 1.0  initial release
// ============================================================================
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_LO: o_taken = w_c;
      COND_HS: o_taken = !w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = !w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = !w_v;
      // C is a borrow flag, so "higher" is no borrow and not equal
      COND_HI: o_taken = !w_c && !w_z;
      COND_LS: o_taken = w_c || w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = !w_z && (w_n == w_v);
      COND_LE: o_taken = w_z || (w_n != w_v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : cond_flag_unit
// Purpose : Architectural status register with one-entry shadow for
//           interrupt save/restore, condition evaluation with a registered
//           valid/ready result, and a saturating evaluation counter.
// Ports   : clk, rst            clock, synchronous active-high reset
//           flags_in [3:0]      {N,Z,C,V} from the compare stage
//           flags_we            load flags_in into the status register
//           flags_save          copy status register into the shadow
//           flags_restore       load shadow into the status register
//           cond [3:0]          condition code, with cond_valid/cond_ready
//           taken, taken_valid  registered result, with taken_ready
//           flags_out [3:0]     current status register
//           eval_count          saturating count of accepted requests
// Rev     : 1.0  initial release
// ============================================================================
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       flags_in,
  input  logic             flags_we,
  input  logic             flags_save,
  input  logic             flags_restore,
  input  logic [3:0]       cond,
  input  logic             cond_valid,
  output logic             cond_ready,
  output logic             taken,
  output logic             taken_valid,
  input  logic             taken_ready,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] eval_count
);

  logic [3:0]       r_flags;
  logic [3:0]       r_shadow;
  logic             r_taken;
  logic             r_taken_valid;
  logic [CNT_W-1:0] r_count;

  logic [3:0]       w_eval_flags;
  logic             w_taken;
  logic             w_accept;

  // Bypass lets a condition see the flags being written this same cycle.
  // A restore is never bypassed, so the stored value is used then.
  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_eval_flags = (flags_we && !flags_restore) ? flags_in : r_flags;
    end else begin : g_no_bypass
      assign w_eval_flags = r_flags;
    end
  endgenerate

  cond_eval u_cond_eval (
    .i_flags (w_eval_flags),
    .i_cond  (cond),
    .o_taken (w_taken)
  );

  // Output buffer is free when empty or being drained this cycle
  assign cond_ready = !r_taken_valid || taken_ready;
  assign w_accept   = cond_valid && cond_ready;

  // Status register and shadow. The shadow samples the pre-update register,
  // so save+restore together naturally swaps the two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags  <= 4'b0000;
      r_shadow <= 4'b0000;
    end else begin
      if (flags_restore) begin
        r_flags <= r_shadow;
      end else if (flags_we) begin
        r_flags <= flags_in;
      end
      if (flags_save) begin
        r_shadow <= r_flags;
      end
    end
  end

  // Result buffer and evaluation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken       <= 1'b0;
      r_taken_valid <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_accept) begin
        r_taken       <= w_taken;
        r_taken_valid <= 1'b1;
        if (!(&r_count)) begin
          r_count <= r_count + 1'b1;
        end
      end else if (taken_ready) begin
        r_taken_valid <= 1'b0;
      end
    end
  end

  assign taken       = r_taken;
  assign taken_valid = r_taken_valid;
  assign flags_out   = r_flags;
  assign eval_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cond_flag_unit
// Purpose : Self-checking bench. Two instances share one stimulus stream:
//           A (BYPASS=1, CNT_W=16) and B (BYPASS=0, CNT_W=4). Each is
//           compared every cycle against a behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags_in;
  logic       flags_we, flags_save, flags_restore;
  logic [3:0] cond;
  logic       cond_valid, taken_ready;

  logic        a_ready, a_taken, a_valid;
  logic [3:0]  a_flags;
  logic [15:0] a_cnt;
  logic        b_ready, b_taken, b_valid;
  logic [3:0]  b_flags;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  cond_flag_unit #(.BYPASS(1), .CNT_W(16)) u_dut_a (
    .clk (clk), .rst (rst), .flags_in (flags_in), .flags_we (flags_we),
    .flags_save (flags_save), .flags_restore (flags_restore),
    .cond (cond), .cond_valid (cond_valid), .cond_ready (a_ready),
    .taken (a_taken), .taken_valid (a_valid), .taken_ready (taken_ready),
    .flags_out (a_flags), .eval_count (a_cnt)
  );

  cond_flag_unit #(.BYPASS(0), .CNT_W(4)) u_dut_b (
    .clk (clk), .rst (rst), .flags_in (flags_in), .flags_we (flags_we),
    .flags_save (flags_save), .flags_restore (flags_restore),
    .cond (cond), .cond_valid (cond_valid), .cond_ready (b_ready),
    .taken (b_taken), .taken_valid (b_valid), .taken_ready (taken_ready),
    .flags_out (b_flags), .eval_count (b_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = instance A, 1 = instance B
  int m_flags [2];
  int m_shadow[2];
  int m_valid [2];
  int m_taken [2];
  int m_cnt   [2];
  int c_max   [2] = '{65535, 15};
  int c_byp   [2] = '{1, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Condition semantics from the flag definitions
  function automatic int ref_eval(input int f, input int c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return int'(z);
      1:  return int'(!z);
      2:  return int'(cy);
      3:  return int'(!cy);
      4:  return int'(n);
      5:  return int'(!n);
      6:  return int'(v);
      7:  return int'(!v);
      8:  return int'(!cy && !z);
      9:  return int'(cy || z);
      10: return int'(n == v);
      11: return int'(n != v);
      12: return int'(!z && (n == v));
      13: return int'(z || (n != v));
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Apply one cycle of inputs, check the combinational ready, advance the
  // model across the clock edge, then check the registered outputs.
  task automatic go(input bit r, input logic [3:0] fi, input bit we,
                    input bit sv, input bit rs, input logic [3:0] c,
                    input bit cv, input bit tr);
    int nf[2], ns[2], nv[2], nt[2], nc[2];
    rst = r; flags_in = fi; flags_we = we; flags_save = sv;
    flags_restore = rs; cond = c; cond_valid = cv; taken_ready = tr;
    #1;
    for (int i = 0; i < 2; i++) begin
      int rdy, src;
      bit acc;
      rdy = (m_valid[i] == 0 || tr) ? 1 : 0;
      chk(i == 0 ? "a_cond_ready" : "b_cond_ready",
          i == 0 ? int'(a_ready) : int'(b_ready), rdy);
      if (r) begin
        nf[i] = 0; ns[i] = 0; nv[i] = 0; nt[i] = 0; nc[i] = 0;
      end else begin
        src = (c_byp[i] == 1 && we && !rs) ? int'(fi) : m_flags[i];
        acc = cv && (rdy == 1);
        nf[i] = rs ? m_shadow[i] : (we ? int'(fi) : m_flags[i]);
        ns[i] = sv ? m_flags[i] : m_shadow[i];
        nv[i] = m_valid[i]; nt[i] = m_taken[i]; nc[i] = m_cnt[i];
        if (acc) begin
          nv[i] = 1;
          nt[i] = ref_eval(src, int'(c));
          nc[i] = (m_cnt[i] < c_max[i]) ? m_cnt[i] + 1 : c_max[i];
        end else if (tr) begin
          nv[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_flags[i] = nf[i]; m_shadow[i] = ns[i]; m_valid[i] = nv[i];
      m_taken[i] = nt[i]; m_cnt[i] = nc[i];
    end
    chk("a_flags_out",   int'(a_flags), m_flags[0]);
    chk("a_taken_valid", int'(a_valid), m_valid[0]);
    chk("a_taken",       int'(a_taken), m_taken[0]);
    chk("a_eval_count",  int'(a_cnt),   m_cnt[0]);
    chk("b_flags_out",   int'(b_flags), m_flags[1]);
    chk("b_taken_valid", int'(b_valid), m_valid[1]);
    chk("b_taken",       int'(b_taken), m_taken[1]);
    chk("b_eval_count",  int'(b_cnt),   m_cnt[1]);
  endtask

  task automatic idle(input logic [3:0] fi, input bit we, input bit sv,
                      input bit rs);
    go(1'b0, fi, we, sv, rs, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_flags[i] = 0; m_shadow[i] = 0; m_valid[i] = 0;
      m_taken[i] = 0; m_cnt[i] = 0;
    end

    // Reset with random inputs; the model state forced to zero by reset
    for (int k = 0; k < 2; k++)
      go(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         4'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_flags_out", int'(a_flags), 0);
    chk("rst_taken_valid", int'(a_valid), 0);
    chk("rst_eval_count", int'(a_cnt), 0);

    // Basic evaluation: Z set, EQ taken then NE not taken
    idle(4'b0100, 1'b1, 1'b0, 1'b0);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("basic_eq", int'(a_taken), 1);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1);
    chk("basic_ne", int'(a_taken), 0);
    idle(4'b0, 1'b0, 1'b0, 1'b0);

    // Bypass: write N with MI in the same cycle
    idle(4'b0000, 1'b1, 1'b0, 1'b0);
    go(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1);
    chk("bypass_a_mi", int'(a_taken), 1);
    chk("bypass_b_mi", int'(b_taken), 0);
    chk("bypass_flags", int'(b_flags), 8);
    idle(4'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: GT then LT with flags 0000 while consumer stalls
    idle(4'b0000, 1'b1, 1'b0, 1'b0);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0);
    chk("bp_held_taken", int'(a_taken), 1);
    go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1);
    chk("bp_second_taken", int'(a_taken), 0);
    idle(4'b0, 1'b0, 1'b0, 1'b0);

    // Save / restore, then simultaneous swap
    idle(4'b0010, 1'b1, 1'b0, 1'b0);
    idle(4'b0, 1'b0, 1'b1, 1'b0);
    idle(4'b1001, 1'b1, 1'b0, 1'b0);
    idle(4'b0, 1'b0, 1'b0, 1'b1);
    chk("restore_flags", int'(a_flags), 2);
    idle(4'b0, 1'b0, 1'b1, 1'b0);
    idle(4'b1100, 1'b1, 1'b0, 1'b0);
    idle(4'b0, 1'b0, 1'b1, 1'b1);
    chk("swap_flags", int'(a_flags), 2);
    idle(4'b0, 1'b0, 1'b0, 1'b1);
    chk("swap_shadow", int'(a_flags), 12);

    // Counter saturation on the narrow instance
    go(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      go(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'd14, 1'b1, 1'b1);
      chk("sat_al_taken", int'(b_taken), 1);
    end
    chk("sat_count_b", int'(b_cnt), 15);
    chk("sat_count_a", int'(a_cnt), 20);

    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      go(($urandom_range(0, 63) == 0), 4'($urandom), 1'($urandom),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
         4'($urandom), ($urandom_range(0, 9) < 7),
         ($urandom_range(0, 9) < 6));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
